imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator with valid/ready flow control for the pipelined RV32I/RV64I core. It decodes the instruction format from the opcode, builds the sign- or zero-extended immediate at XLEN width, and tags each result with its format and an illegal flag. A 2-entry skid buffer sustains one instruction per cycle under downstream back-pressure. It sits between the fetch/IF-ID register and the ID-stage operand mux.

---
 rtl/imm_gen_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer on valid/ready.
// Define IMM_GEN_PERF_EN to add the perf_insn_cnt / perf_illegal_cnt counters.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [31:0]      perf_insn_cnt,
  output logic [31:0]      perf_illegal_cnt
`endif
);

  localparam int unsigned INSTR_W = 32;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ILL   = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d, dec;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire, out_fire, is_shift;
  logic [INSTR_W-1:0] imm32;
  logic   sext;

  assign in_ready = ~rst & ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign is_shift = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);

  // Decode: build a 32-bit pattern, then sign- or zero-extend to XLEN.
  always_comb begin
    imm32       = '0;
    sext        = 1'b0;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    case (in_instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        sext    = 1'b1;
      end
      OP_IMM: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          imm32   = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        end else begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          sext    = 1'b1;
        end
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec.fmt = FMT_SHAMT;
            imm32   = {27'b0, in_instr[24:20]};
          end else begin
            dec.fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            sext    = 1'b1;
          end
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        sext    = 1'b1;
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        sext    = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
        sext    = 1'b1;
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        sext    = 1'b1;
      end
      OP_OP:   dec.fmt = FMT_R;
      OP_OP32: dec.fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default: dec.fmt = FMT_ILL;
    endcase
    dec.illegal = (dec.fmt == FMT_ILL);
    dec.imm     = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    dec.tag     = in_tag;
  end

  // Skid buffer: the output register refills from skid first, else from the input.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (~out_valid_q | out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

`ifdef IMM_GEN_PERF_EN
  logic [31:0] perf_insn_q, perf_insn_d, perf_ill_q, perf_ill_d;

  always_comb begin
    perf_insn_d = perf_insn_q;
    perf_ill_d  = perf_ill_q;
    if (out_fire) begin
      perf_insn_d = perf_insn_q + 32'd1;
      if (out_q.illegal) perf_ill_d = perf_ill_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_insn_q <= '0;
      perf_ill_q  <= '0;
    end else begin
      perf_insn_q <= perf_insn_d;
      perf_ill_q  <= perf_ill_d;
    end
  end

  assign perf_insn_cnt    = perf_insn_q;
  assign perf_illegal_cnt = perf_ill_q;
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances in lockstep against a queue model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [3:0]  tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [3:0]  tag64;
`ifdef IMM_GEN_PERF_EN
  logic [31:0] pi32, pl32, pi64, pl64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
`ifdef IMM_GEN_PERF_EN
    , .perf_insn_cnt(pi32), .perf_illegal_cnt(pl32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
`ifdef IMM_GEN_PERF_EN
    , .perf_insn_cnt(pi64), .perf_illegal_cnt(pl64)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b0;

  typedef struct {
    logic [63:0] imm32, imm64;
    logic [2:0]  fmt32, fmt64;
    logic        ill32, ill64;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];
  int   tag_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint raw, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (raw >= half) ? raw - (half * 2) : raw;
  endfunction

  // Reference decode from the ISA field definitions using integer arithmetic.
  function automatic void model(input logic [31:0] ins, input int xlen,
                                output logic [63:0] imm, output logic [2:0] fmt,
                                output logic ill);
    longint v;
    bit     shift;
    v     = 0;
    fmt   = 3'd7;
    shift = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
      7'b0010011:
        if (shift) begin
          fmt = 3'd6;
          v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          fmt = 3'd1; v = sx(longint'(ins[31:20]), 12);
        end
      7'b0011011:
        if (xlen == 64) begin
          if (shift) begin fmt = 3'd6; v = longint'(ins[24:20]); end
          else begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
        end
      7'b0100011: begin
        fmt = 3'd2;
        v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end
      7'b1100011: begin
        fmt = 3'd3;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      7'b0110111, 7'b0010111: begin fmt = 3'd4; v = sx(longint'(ins[31:12]) * 4096, 32); end
      7'b1101111: begin
        fmt = 3'd5;
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      7'b0110011: fmt = 3'd0;
      7'b0111011: if (xlen == 64) fmt = 3'd0;
      default: fmt = 3'd7;
    endcase
    ill = (fmt == 3'd7);
    imm = (xlen == 32) ? {32'h0, v[31:0]} : v[63:0];
  endfunction

  // Scoreboard: occupancy drives expected in_ready/out_valid, front entry drives out_*.
  always @(negedge clk) begin
    if (sb_en) begin
      exp_t e;
      chk("in_ready32", in_ready32, !rst && exp_q.size() < 2);
      chk("in_ready64", in_ready64, !rst && exp_q.size() < 2);
      chk("out_valid32", out_valid32, exp_q.size() > 0);
      chk("out_valid64", out_valid64, exp_q.size() > 0);
      if (exp_q.size() > 0 && out_valid32) begin
        e = exp_q[0];
        chk("imm32", 64'(imm32), e.imm32);
        chk("fmt32", fmt32, e.fmt32);
        chk("ill32", ill32, e.ill32);
        chk("tag32", tag32, e.tag);
        chk("imm64", imm64, e.imm64);
        chk("fmt64", fmt64, e.fmt64);
        chk("ill64", ill64, e.ill64);
        chk("tag64", tag64, e.tag);
        if (out_ready) begin
          void'(exp_q.pop_front());
          tag_log.push_back(int'(tag32));
        end
      end
      if (rst) exp_q.delete();
      else if (in_valid && in_ready32) begin
        model(in_instr, 32, e.imm32, e.fmt32, e.ill32);
        model(in_instr, 64, e.imm64, e.fmt64, e.ill64);
        e.tag = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and return just after the edge that accepts it.
  task automatic send(input logic [31:0] ins, input logic [3:0] tag);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready32) begin ok = 1'b1; break; end
    end
    chk("send_timeout", ok, 1'b1);
    step();
  endtask

  task automatic send_lit(input logic [31:0] ins, input logic [31:0] eimm, input logic [2:0] efmt,
                          input logic eill);
    send(ins, 4'hA);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_valid", out_valid32, 1'b1);
    chk("lit_imm", 64'(imm32), 64'(eimm));
    chk("lit_fmt", fmt32, efmt);
    chk("lit_ill", ill32, eill);
    step();
  endtask

  logic [31:0] lit_ins [7] = '{32'h7FF00203, 32'hFFF00203, 32'h03A12123, 32'hFFE080E3,
                               32'h012340B7, 32'h00F400EF, 32'h40315093};
  logic [31:0] lit_imm [7] = '{32'h000007FF, 32'hFFFFFFFF, 32'h00000022, 32'hFFFFFFE0,
                               32'h01234000, 32'h0004080E, 32'h00000003};
  logic [2:0]  lit_fmt [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

  logic [31:0] stream [8] = '{32'h00A00093, 32'h0000003B, 32'h7FF00203, 32'h00F400EF,
                              32'h0000101B, 32'hFFFFF0B7, 32'h02515093, 32'hFFFFFFFF};
  logic [11:0] rdy_pat = 12'b101100111010;

  initial begin
    logic [63:0] mimm;
    logic [2:0]  mfmt;
    logic        mill;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready32, 1'b0);
    step();
    @(negedge clk);
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_imm", 64'(imm32), 64'h0);
    chk("rst_fmt", fmt32, 3'd0);
    chk("rst_ill", ill32, 1'b0);
    chk("rst_tag", tag32, 4'h0);
    chk("rst_imm64", imm64, 64'h0);
    step();
    rst   = 1'b0;
    sb_en = 1'b1;

    // Pin the model against hand-derived values.
    model(32'hFFF00203, 64, mimm, mfmt, mill);
    chk("model_i64", mimm, 64'hFFFFFFFF_FFFFFFFF);
    model(32'hFFE080E3, 32, mimm, mfmt, mill);
    chk("model_b32", mimm, 64'h00000000_FFFFFFE0);
    model(32'h0000101B, 32, mimm, mfmt, mill);
    chk("model_w32_ill", {mill, mfmt}, {1'b1, 3'd7});
    model(32'h02515093, 64, mimm, mfmt, mill);
    chk("model_shamt64", mimm, 64'd37);

    for (int i = 0; i < 7; i++) send_lit(lit_ins[i], lit_imm[i], lit_fmt[i], 1'b0);
    send_lit(32'h0000101B, 32'h0, 3'd7, 1'b1);

    send(32'hFFF00203, 4'h5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
    step();
    send(32'h0000003B, 4'h6);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_addw64_fmt", {ill64, fmt64}, {1'b0, 3'd0});
    chk("lit_addw32_fmt", {ill32, fmt32}, {1'b1, 3'd7});
    step();

    // Back-to-back stream against a fixed back-pressure pattern.
    fork
      begin
        for (int i = 0; i < 8; i++) send(stream[i], 4'(i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = rdy_pat[c];
          step();
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) step();

    // Back-pressure: tags 1 and 2 held, tag 3 stalled, then drained in order.
    tag_log.delete();
    out_ready = 1'b0;
    send(32'h00100093, 4'd1);
    send(32'h00200093, 4'd2);
    in_instr = 32'h00300093;
    in_tag   = 4'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready32, 1'b0);
      chk("bp_hold_tag", tag32, 4'd1);
    end
    step();
    out_ready = 1'b1;
    send(32'h00300093, 4'd3);
    in_valid = 1'b0;
    repeat (3) step();
    chk("bp_count", 64'(tag_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < tag_log.size(); i++) chk("bp_order", 64'(tag_log[i]), 64'(i + 1));

    // Reset with two entries held.
    out_ready = 1'b0;
    send(32'h00400093, 4'd4);
    send(32'h00500093, 4'd5);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready32, 1'b0);
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid32, 1'b0);
    chk("mid_rst_in_ready2", in_ready32, 1'b0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready32, 1'b1);
    chk("post_rst_out_valid", out_valid32, 1'b0);
    repeat (3) step();

`ifdef IMM_GEN_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(32'h00A00093, 4'd1);
    send(32'h0000101B, 4'd2);
    send(32'h03A12123, 4'd3);
    send(32'hFFFFFFFF, 4'd4);
    send(32'h012340B7, 4'd5);
    in_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("perf_insn32", pi32, 32'd5);
    chk("perf_ill32", pl32, 32'd2);
    chk("perf_insn64", pi64, 32'd5);
    chk("perf_ill64", pl64, 32'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("perf_rst_insn", pi32, 32'd0);
    chk("perf_rst_ill", pl32, 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
`endif

    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
